uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between up to N_REQ message senders: end-game event, board dump, score update, and others.
- Grants whole-message ownership, so bytes from different senders never interleave.
- Muxes the granted sender's tx_data/send onto the UART and gates busy back to every requester.
- Sits between the event TX FSMs and the UART TX core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 50000, cycles a grant may sit with no forwarded send before it is revoked.
- OWN_W, $clog2(N_REQ), width of the owner index (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester ownership request, held high for the whole message
- req_send  in  N_REQ  per-requester single-cycle byte strobe
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- grant  out  N_REQ  one-hot ownership; registered
- req_busy  out  N_REQ  busy seen by each requester: 1 if not granted, else tx_busy
- tx_data  out  8  byte to UART; registered
- tx_send  out  1  send strobe to UART; registered, 1 cycle
- tx_busy  in  1  UART busy
- data_sent  in  1  UART byte-complete pulse
- owner  out  OWN_W  index of current/last grantee
- active  out  1  a grant is held
- byte_count  out  8  bytes forwarded in the current message; saturates at 255
- timeout  out  1  1-cycle pulse when a grant is revoked by timeout
- collision  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async): state=IDLE; grant=0, tx_data=0, tx_send=0, owner=N_REQ-1, active=0, byte_count=0, timeout=0, collision=0; idle counter=0.
- Default every cycle: tx_send<=0, timeout<=0.
- IDLE:
  - If req!=0, choose the first set bit searching circularly from owner+1.
  - Next cycle: grant<=onehot(choice), owner<=choice, active<=1, byte_count<=0, go ACTIVE.
  - Grant latency is exactly 1 cycle after req is sampled.
- ACTIVE:
  - Granted requester g asserts req_send[g] while tx_busy=0: next cycle tx_data<=req_data[g], tx_send<=1, byte_count++ (saturating), idle counter cleared.
  - req_send[g] while tx_busy=1: byte not forwarded; collision<=1.
  - req_send[i] for any i!=g: ignored; collision<=1.
  - req[g]=0: go DRAIN. A req_send[g] in that same cycle is still forwarded.
  - Idle counter increments each cycle with no forwarded send. Reaching TIMEOUT_CYC-1: timeout<=1, go DRAIN.
- DRAIN:
  - Wait for tx_busy=0 and no tx_send in flight. tx_send was asserted the previous cycle, so require a full cycle of tx_busy=0 after it.
  - Then grant<=0, active<=0, go IDLE.
  - owner keeps the last grantee, which seeds round-robin.
  - At least one IDLE cycle always separates two grants.
- Simultaneous requests: round-robin only. The same requester cannot win twice in a row while another is waiting.
- Requester that drops req before it is granted: never granted; no effect.
- Reset mid-message: grant drops immediately (async). The UART may finish its current byte; that is the UART's concern.
- data_sent: not used for sequencing. It is qualified only to keep DRAIN from exiting in the cycle it pulses, if tx_busy glitches low.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. When req[0]=1 in IDLE it is chosen regardless of owner. All others remain round-robin among themselves, and requester 0 still never preempts an active grant.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: req=4'b0001 at cycle t -> grant=0001 at t+1, active=1. Three sends of AE,10,FF with tx_busy idle -> tx_data sequence AE,10,FF, byte_count=3. req low -> grant=0 once tx_busy has been low one cycle.
- Contention: req=4'b1010 with owner=3 after reset -> grant 0010 first. Then grant 1000 after requester 1 releases, with one IDLE cycle between the grants.
- Collision: while owner=1, req_send[3]=1 -> tx_send stays 0, collision=1 and sticky until reset. req_send[1] with tx_busy=1 -> not forwarded, collision=1.
- Timeout (TIMEOUT_CYC=16): grant held with no sends -> timeout pulse 16 cycles after the last activity, grant=0 afterward, next requester served.
- Reset during message: assert reset mid-ACTIVE -> grant, tx_send, active, byte_count all 0 immediately; owner=N_REQ-1.
- UART_ARB_PRIO0_EN: req=1111 repeatedly re-raised -> requester 0 wins every free arbitration. Without the macro -> order 0,1,2,3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Arbitrates whole-message ownership of one UART transmitter among N_REQ senders.
// Define UART_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin others.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int OWN_W       = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_send,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   req_busy,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy,
  input  logic               data_sent,
  output logic [OWN_W-1:0]   owner,
  output logic               active,
  output logic [7:0]         byte_count,
  output logic               timeout,
  output logic               collision
);

  // Handshake: req is held for a whole message; a req_send strobe is accepted
  // only from the granted requester while its req_busy (tx_busy) is low, and
  // tx_send is a 1-cycle strobe the UART takes unconditionally.

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [OWN_W-1:0]  OWN_RST = OWN_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] idle_cnt;
  logic [OWN_W-1:0] rr_seed;
  logic [OWN_W-1:0] pick_idx;
  logic             pick_valid;
  int               idx;
  logic             send_g, hold_g, other_send;
  logic [7:0]       fwd_byte;
  logic             do_grant, do_fwd, do_release, set_coll, do_timeout;

`ifdef UART_ARB_PRIO0_EN
  // Round-robin among requesters 1..N-1 must not be disturbed by requester 0 wins.
  logic [OWN_W-1:0] rr_last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_last <= OWN_RST;
    else if (do_grant && (pick_idx != '0))
      rr_last <= pick_idx;
  end
  assign rr_seed = rr_last;
`else
  assign rr_seed = owner;
`endif

  // First requester found circularly after the seed; smallest distance wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_seed) + k) % N_REQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = OWN_W'(idx);
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  always_comb begin
    send_g   = 1'b0;
    hold_g   = 1'b0;
    fwd_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == OWN_W'(i)) begin
        send_g   = req_send[i];
        hold_g   = req[i];
        fwd_byte = req_data[8*i +: 8];
      end
    end
    other_send = |(req_send & ~grant);
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      req_busy[i] = grant[i] ? tx_busy : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_fwd     = 1'b0;
    do_release = 1'b0;
    set_coll   = 1'b0;
    do_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          do_grant = 1'b1;
          state_n  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (send_g) begin
          if (tx_busy) set_coll = 1'b1;
          else         do_fwd   = 1'b1;
        end
        if (other_send) set_coll = 1'b1;
        if (!hold_g) begin
          state_n = S_DRAIN;
        end else if (!do_fwd && (idle_cnt == TO_LAST)) begin
          do_timeout = 1'b1;
          state_n    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // tx_send high means the UART has not yet had a cycle to raise busy.
        if (!tx_busy && !tx_send && !data_sent) begin
          do_release = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      owner      <= OWN_RST;
      active     <= 1'b0;
      byte_count <= '0;
      timeout    <= 1'b0;
      collision  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      tx_send <= 1'b0;
      timeout <= do_timeout;
      if (set_coll) collision <= 1'b1;
      if (do_grant) begin
        grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
        owner      <= pick_idx;
        active     <= 1'b1;
        byte_count <= '0;
        idle_cnt   <= '0;
      end
      if (do_fwd) begin
        tx_data  <= fwd_byte;
        tx_send  <= 1'b1;
        idle_cnt <= '0;
        if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
      end else if (state == S_ACTIVE) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
      if (do_release) begin
        grant  <= '0;
        active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle comparison against a message-level model
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req, req_send;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     grant, req_busy;
  logic [7:0]       tx_data;
  logic             tx_send, tx_busy, data_sent;
  logic [1:0]       owner;
  logic             active, timeout, collision;
  logic [7:0]       byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_send(req_send), .req_data(req_data),
    .grant(grant), .req_busy(req_busy), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .data_sent(data_sent), .owner(owner), .active(active),
    .byte_count(byte_count), .timeout(timeout), .collision(collision)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active, m_drain, m_send, m_timeout, m_coll, prev_send, fwd;
  int         m_owner, m_count, m_quiet, m_rr, w, g;
  logic [7:0] m_data;

  function automatic int rr_pick(input logic [N-1:0] r, input int seed);
    rr_pick = -1;
    for (int k = 1; k <= N; k++)
      if (r[(seed + k) % N] && rr_pick < 0) rr_pick = (seed + k) % N;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 0; m_drain = 0; m_send = 0; m_timeout = 0; m_coll = 0;
        m_owner = N - 1; m_rr = N - 1; m_count = 0; m_quiet = 0; m_data = 8'h00;
      end else begin
        prev_send = m_send;
        m_send    = 0;
        m_timeout = 0;
        if (!m_active) begin
`ifdef UART_ARB_PRIO0_EN
          w = req[0] ? 0 : rr_pick(req, m_rr);
`else
          w = rr_pick(req, m_owner);
`endif
          if (w >= 0) begin
            m_active = 1; m_drain = 0; m_owner = w; m_count = 0; m_quiet = 0;
            if (w != 0) m_rr = w;
          end
        end else if (!m_drain) begin
          g   = m_owner;
          fwd = req_send[g] && !tx_busy;
          if (req_send[g] && tx_busy) m_coll = 1;
          for (int i = 0; i < N; i++)
            if (i != g && req_send[i]) m_coll = 1;
          if (fwd) begin
            m_data = req_data[8*g +: 8];
            m_send = 1;
            if (m_count < 255) m_count++;
            m_quiet = 0;
          end else begin
            m_quiet++;
          end
          if (!req[g]) m_drain = 1;
          else if (m_quiet == TO) begin
            m_timeout = 1;
            m_drain   = 1;
          end
        end else if (!tx_busy && !prev_send && !data_sent) begin
          m_active = 0;
          m_drain  = 0;
        end
      end
    end
  end

  // scoreboard: every cycle, outputs vs model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en && !reset) begin
        chk("grant",      grant,      m_active ? (32'd1 << m_owner) : 32'd0);
        chk("active",     active,     m_active);
        chk("owner",      owner,      m_owner);
        chk("tx_send",    tx_send,    m_send);
        chk("tx_data",    tx_data,    m_data);
        chk("byte_count", byte_count, m_count);
        chk("timeout",    timeout,    m_timeout);
        chk("collision",  collision,  m_coll);
        for (int i = 0; i < N; i++)
          chk("req_busy", req_busy[i], (m_active && m_owner == i) ? tx_busy : 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1; req = '0; req_send = '0; req_data = '0; tx_busy = 0; data_sent = 0;
    @(negedge clk);
    reset  = 0;
    chk_en = 1;
  endtask

  task automatic send(input int i, input logic [7:0] b);
    @(negedge clk);
    req_data[8*i +: 8] = b;
    req_send[i] = 1'b1;
    @(negedge clk);
    req_send = '0;
  endtask

  task automatic wait_active(input logic want);
    int n = 0;
    while (active !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_active", active, want);
  endtask

  logic [1:0] exp_order [4];

  initial begin
    reset = 0; req = '0; req_send = '0; req_data = '0; tx_busy = 0; data_sent = 0;
    #1 reset = 1;

    // reset values
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_owner", owner, 2'd3);
    chk("rst_active", active, 1'b0);
    chk("rst_bytes", byte_count, 8'd0);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_coll", collision, 1'b0);
    chk("rst_req_busy", req_busy, 4'b1111);

    // single request, three bytes, drain waits on busy and data_sent
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_active", active, 1'b1);
    send(0, 8'hAE); chk("t1_b0", tx_data, 8'hAE); chk("t1_send0", tx_send, 1'b1);
    send(0, 8'h10); chk("t1_b1", tx_data, 8'h10);
    send(0, 8'hFF); chk("t1_b2", tx_data, 8'hFF);
    chk("t1_count", byte_count, 8'd3);
    req = 4'b0000; tx_busy = 1;
    repeat (3) @(negedge clk);
    chk("t1_hold_busy", grant, 4'b0001);
    tx_busy = 0; data_sent = 1;
    @(negedge clk);
    chk("t1_hold_sent", grant, 4'b0001);
    data_sent = 0;
    @(negedge clk);
    chk("t1_release", grant, 4'b0000);
    chk("t1_inactive", active, 1'b0);

    // contention: 1 then 3 with an idle cycle between
    do_reset();
    req = 4'b1010;
    @(negedge clk);
    chk("t2_first", grant, 4'b0010);
    req = 4'b1000;
    @(negedge clk); chk("t2_drain", grant, 4'b0010);
    @(negedge clk); chk("t2_gap", grant, 4'b0000);
    @(negedge clk); chk("t2_second", grant, 4'b1000);
    chk("t2_owner", owner, 2'd3);
    req = 4'b0000;
    wait_active(1'b0);

    // collision: own send while busy, then foreign send
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    tx_busy = 1; req_send = 4'b0010;
    @(negedge clk);
    chk("t3_busy_nosend", tx_send, 1'b0);
    chk("t3_busy_coll", collision, 1'b1);
    chk("t3_busy_count", byte_count, 8'd0);
    req_send = '0; tx_busy = 0;
    do_reset();
    chk("t3_coll_cleared", collision, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    req_send = 4'b1000;
    @(negedge clk);
    chk("t3_foreign_nosend", tx_send, 1'b0);
    chk("t3_foreign_coll", collision, 1'b1);
    req_send = '0;
    repeat (5) @(negedge clk);
    chk("t3_sticky", collision, 1'b1);
    req = 4'b0000;
    wait_active(1'b0);
    chk("t3_sticky_idle", collision, 1'b1);

    // timeout after TO silent cycles, next requester served
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    chk("t4_grant", grant, 4'b0001);
    repeat (15) @(negedge clk);
    chk("t4_no_to_yet", timeout, 1'b0);
    @(negedge clk);
    chk("t4_to_pulse", timeout, 1'b1);
    chk("t4_to_grant", grant, 4'b0001);
    @(negedge clk);
    chk("t4_to_clear", timeout, 1'b0);
    chk("t4_revoked", grant, 4'b0000);
    @(negedge clk);
    chk("t4_next", grant, 4'b0010);
    req = 4'b0000;
    wait_active(1'b0);

    // byte_count saturation
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    req_send = 4'b0001; req_data[7:0] = 8'h3C;
    repeat (260) @(negedge clk);
    req_send = '0;
    chk("t5_saturate", byte_count, 8'd255);
    req = 4'b0000;
    wait_active(1'b0);

    // reset mid-message
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    send(2, 8'h5A);
    chk("t6_pre_send", tx_send, 1'b1);
    reset = 1;
    #1;
    chk("t6_grant", grant, 4'b0000);
    chk("t6_tx_send", tx_send, 1'b0);
    chk("t6_active", active, 1'b0);
    chk("t6_bytes", byte_count, 8'd0);
    chk("t6_owner", owner, 2'd3);
    req = 4'b0000;
    @(negedge clk);
    reset = 0;

    // fairness with all requesters re-raising
`ifdef UART_ARB_PRIO0_EN
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_active(1'b1);
      chk("t7_order", owner, exp_order[n]);
      req[exp_order[n]] = 1'b0;
      wait_active(1'b0);
      req[exp_order[n]] = 1'b1;
    end
    req = 4'b0000;
    wait_active(1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
